// File: rtl/siso_stream_pkg.sv
// ---------------------------------------------------------------------------
// siso_stream_pkg
// Shared definitions for the serial stream receiver:
//   - state_e       : FSM state encoding (ST_IDLE, ST_SHIFT, ST_PARITY, ST_DONE)
//   - DEFAULT_WIDTH : default number of data bits per frame
//   - cnt_width()   : width of the in-frame bit counter for a given WIDTH
// ---------------------------------------------------------------------------
package siso_stream_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/siso_stream_shreg.sv
// ---------------------------------------------------------------------------
// siso_stream_shreg
// WIDTH-bit receive shift register with selectable fill direction.
//   MSB_FIRST=0 : new bits enter at the top and move down, so after WIDTH
//                 shifts the first received bit sits in q[0].
//   MSB_FIRST=1 : new bits enter at the bottom and move up, so after WIDTH
//                 shifts the first received bit sits in q[WIDTH-1].
// Ports:
//   clk      in  rising-edge clock
//   rst_n    in  asynchronous active-low reset (clears the register)
//   shift_en in  shift din in on this edge
//   din      in  serial bit
//   q        out current register contents
// ---------------------------------------------------------------------------
module siso_stream_shreg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  generate
    if (MSB_FIRST) begin : g_msb_first
      always_comb begin
        q_d = q_q;
        if (shift_en) q_d = {q_q[WIDTH-2:0], din};
      end
    end else begin : g_lsb_first
      always_comb begin
        q_d = q_q;
        if (shift_en) q_d = {din, q_q[WIDTH-1:1]};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/siso_stream_rx.sv
// ---------------------------------------------------------------------------
// siso_stream_rx
// Receives frames from a one-bit serial stream: a start bit (1) followed by
// WIDTH data bits (and one even-parity bit when SISO_STREAM_RX_PARITY_EN is
// defined), all qualified by the en1 bit strobe. Each completed word is
// offered on dout with a valid/ready handshake.
//
// Optional feature macro: SISO_STREAM_RX_PARITY_EN
//   defined   : PARITY state present, parity_err reports the parity check of
//               the word currently on dout.
//   undefined : frame is start + WIDTH data bits, parity_err tied to 0.
//
// Handshake: a word is transferred on a clk1 rising edge where valid=1 and
// ready=1. dout is stable while valid=1. ready is ignored while valid=0. If a
// new word completes while the old one is still pending (valid=1, ready=0)
// the new word is dropped and overrun is set (sticky until reset).
//
// Ports:
//   clk1       in   system clock
//   rst_n      in   asynchronous active-low reset
//   in1        in   serial data
//   en1        in   bit strobe, in1 sampled only when en1=1
//   dout       out  received word
//   valid      out  dout holds an unconsumed word
//   ready      in   consumer accepts word
//   busy       out  frame in progress (state != IDLE)
//   overrun    out  sticky word-dropped flag
//   parity_err out  parity result for current dout
//   dbg_state  out  current FSM state encoding (state_e)
// ---------------------------------------------------------------------------
module siso_stream_rx
  import siso_stream_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             in1,
  input  logic             en1,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err,
  output logic [1:0]       dbg_state
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             shift_en;
  logic [WIDTH-1:0] sr_word;

`ifdef SISO_STREAM_RX_PARITY_EN
  logic par_bit_q, par_bit_d;
  logic perr_q, perr_d;
`endif

  siso_stream_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk      (clk1),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .din      (in1),
    .q        (sr_word)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    shift_en  = 1'b0;
`ifdef SISO_STREAM_RX_PARITY_EN
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
`endif

    // Consumer takes the pending word; DONE below may re-assert valid on
    // the same edge with a fresh word.
    if (valid_q && ready) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en1 && in1) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (en1) begin
          shift_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            // Leave before the counter would pass WIDTH-1.
            cnt_d = '0;
`ifdef SISO_STREAM_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_DONE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef SISO_STREAM_RX_PARITY_EN
      ST_PARITY: begin
        if (en1) begin
          par_bit_d = in1;
          state_d   = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!valid_q || ready) begin
          dout_d  = sr_word;
          valid_d = 1'b1;
`ifdef SISO_STREAM_RX_PARITY_EN
          perr_d  = (^sr_word) ^ par_bit_q;
`endif
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SISO_STREAM_RX_PARITY_EN
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
